// File: rtl/bomberman_pkg.sv
// bomberman_pkg: shared grid constants, coordinate type, button indices, seven-segment glyphs and move/blast helpers.
package bomberman_pkg;
  localparam int GRID = 8;
  localparam int START_HEALTH = 3;
  localparam int NBTN = 5;
  localparam int BTN_UP = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_LEFT = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_BOMB = 4;
  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
  } coord_t;
  typedef enum logic [1:0] {DIG3, DIG2, DIG1, DIG0} dig_e;
  localparam coord_t B_START = '{x: 3'(GRID - 1), y: 3'(GRID - 1)};
  // Glyphs are {dp,g,f,e,d,c,b,a}, active-low, dp always off.
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [7:0] SEG_O = 8'hA3;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [9:0][7:0] SEG_DIGITS = {SEG_9, SEG_8, SEG_7, SEG_6, SEG_5,
                                            SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};

  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    return d < 4'd10 ? SEG_DIGITS[d] : SEG_BLANK;
  endfunction

  // Only the highest-priority press is applied; if it points off the grid nothing moves.
  function automatic coord_t mv_step(input coord_t p, input logic [NBTN-1:0] pr);
    coord_t n;
    n = p;
    if (pr[BTN_UP]) n.y = p.y == 3'd0 ? p.y : p.y - 3'd1;
    else if (pr[BTN_DOWN]) n.y = p.y == 3'(GRID - 1) ? p.y : p.y + 3'd1;
    else if (pr[BTN_LEFT]) n.x = p.x == 3'd0 ? p.x : p.x - 3'd1;
    else if (pr[BTN_RIGHT]) n.x = p.x == 3'(GRID - 1) ? p.x : p.x + 3'd1;
    return n;
  endfunction

  function automatic logic in_blast(input coord_t b, input coord_t p);
    logic [3:0] bx, by, px, py;
    bx = {1'b0, b.x};
    by = {1'b0, b.y};
    px = {1'b0, p.x};
    py = {1'b0, p.y};
    return (bx == px && (by == py || by + 4'd1 == py || py + 4'd1 == by)) ||
           (by == py && (bx + 4'd1 == px || px + 4'd1 == bx));
  endfunction
endpackage

// File: rtl/bm_debounce.sv
// bm_debounce: samples synchronised buttons every DEB_PERIOD cycles and pulses once per rising stable edge.
module bm_debounce
  import bomberman_pkg::*;
#(
  parameter int DEB_PERIOD = 10000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] raw_i,
  output logic [NBTN-1:0] press_o
);
  localparam int CW = $clog2(DEB_PERIOD + 1);
  logic [CW-1:0] cnt_q;
  logic [NBTN-1:0] s1_q, s2_q, stable_q, press_q;
  logic tick;
  assign tick = cnt_q == CW'(DEB_PERIOD - 1);
  always_ff @(posedge clk)
    if (rst) begin
      cnt_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      stable_q <= '0;
      press_q <= '0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
      stable_q <= tick ? s2_q : stable_q;
      press_q <= tick ? s2_q & ~stable_q : '0;
    end
  assign press_o = press_q;
endmodule

// File: rtl/bomberman_game.sv
// bomberman_game: two-player grid bomb game with health display and VGA sync.
// Define BOMBERMAN_POS_DISPLAY_EN to show player coordinates instead of health while sw[0]=1.
module bomberman_game
  import bomberman_pkg::*;
#(
  parameter int BOMB_PERIOD = 100000,
  parameter int DEB_PERIOD = 10000,
  parameter int REFRESH_W = 17
) (
  input  logic       clk,
  input  logic [7:0] sw,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnS,
  input  logic [7:0] JA,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       hsync,
  output logic       vsync
);
  localparam int FUSE = 2 * BOMB_PERIOD;
  localparam int FW = $clog2(FUSE + 1);
  logic rst, over, pos_en, unused;
  logic [NBTN-1:0] pr_a, pr_b;
  coord_t pa_q, pb_q, ba_q, bb_q;
  logic ba_act_q, bb_act_q, exp_a, exp_b, arm_a, arm_b;
  logic [FW-1:0] ba_cnt_q, bb_cnt_q;
  logic [1:0] ha_q, hb_q, ha_d, hb_d, hit_a, hit_b;
  logic [REFRESH_W-1:0] ref_q;
  dig_e sel;
  logic [7:0] seg_q, glyph, mid;
  logic [3:0] an_q;
  logic [1:0] pix_q;
  logic [9:0] h_q, v_q;
  logic hs_q, vs_q;

  assign rst = sw[7];
`ifdef BOMBERMAN_POS_DISPLAY_EN
  assign pos_en = sw[0];
  assign unused = ^{sw[6:1], JA[7:5]};
`else
  assign pos_en = 1'b0;
  assign unused = ^{sw[6:0], JA[7:5]};
`endif

  bm_debounce #(.DEB_PERIOD(DEB_PERIOD)) u_deb_a (
    .clk(clk), .rst(rst), .raw_i({btnS, btnR, btnL, btnD, btnU}), .press_o(pr_a)
  );
  bm_debounce #(.DEB_PERIOD(DEB_PERIOD)) u_deb_b (
    .clk(clk), .rst(rst), .raw_i(JA[4:0]), .press_o(pr_b)
  );

  assign over = ha_q == 2'd0 || hb_q == 2'd0;
  assign exp_a = !over && ba_act_q && ba_cnt_q == FW'(FUSE - 1);
  assign exp_b = !over && bb_act_q && bb_cnt_q == FW'(FUSE - 1);
  assign arm_a = !over && !ba_act_q && pr_a[BTN_BOMB];
  assign arm_b = !over && !bb_act_q && pr_b[BTN_BOMB];
  // Overlapping blasts in the same cycle stack, so a player can lose two points at once.
  assign hit_a = {1'b0, exp_a && in_blast(ba_q, pa_q)} + {1'b0, exp_b && in_blast(bb_q, pa_q)};
  assign hit_b = {1'b0, exp_a && in_blast(ba_q, pb_q)} + {1'b0, exp_b && in_blast(bb_q, pb_q)};
  assign ha_d = ha_q > hit_a ? ha_q - hit_a : 2'd0;
  assign hb_d = hb_q > hit_b ? hb_q - hit_b : 2'd0;

  always_ff @(posedge clk)
    if (rst) begin
      pa_q <= '0;
      pb_q <= B_START;
      ha_q <= 2'(START_HEALTH);
      hb_q <= 2'(START_HEALTH);
      ba_q <= '0;
      bb_q <= '0;
      ba_act_q <= 1'b0;
      bb_act_q <= 1'b0;
      ba_cnt_q <= '0;
      bb_cnt_q <= '0;
    end else begin
      pa_q <= over ? pa_q : mv_step(pa_q, pr_a);
      pb_q <= over ? pb_q : mv_step(pb_q, pr_b);
      ha_q <= ha_d;
      hb_q <= hb_d;
      ba_q <= arm_a ? pa_q : ba_q;
      bb_q <= arm_b ? pb_q : bb_q;
      ba_act_q <= !over && (ba_act_q ? !exp_a : pr_a[BTN_BOMB]);
      bb_act_q <= !over && (bb_act_q ? !exp_b : pr_b[BTN_BOMB]);
      ba_cnt_q <= ba_act_q ? ba_cnt_q + 1'b1 : '0;
      bb_cnt_q <= bb_act_q ? bb_cnt_q + 1'b1 : '0;
    end

  assign sel = dig_e'(ref_q[REFRESH_W-1 -: 2]);
  assign mid = over ? SEG_O : SEG_DASH;
  assign glyph = sel == DIG3 ? (pos_en ? seg_digit({1'b0, pa_q.x}) : seg_digit({2'b0, ha_q}))
               : sel == DIG2 ? (pos_en ? seg_digit({1'b0, pa_q.y}) : mid)
               : sel == DIG1 ? (pos_en ? seg_digit({1'b0, pb_q.x}) : mid)
               : (pos_en ? seg_digit({1'b0, pb_q.y}) : seg_digit({2'b0, hb_q}));

  always_ff @(posedge clk)
    if (rst) begin
      ref_q <= '0;
      seg_q <= 8'hFF;
      an_q <= 4'hF;
    end else begin
      ref_q <= ref_q + 1'b1;
      seg_q <= glyph;
      an_q <= ~(4'b1000 >> sel);
    end

  always_ff @(posedge clk)
    if (rst) begin
      pix_q <= '0;
      h_q <= '0;
      v_q <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else begin
      pix_q <= pix_q + 2'd1;
      h_q <= pix_q == 2'd3 ? (h_q == 10'd799 ? '0 : h_q + 10'd1) : h_q;
      v_q <= (pix_q == 2'd3 && h_q == 10'd799) ? (v_q == 10'd524 ? '0 : v_q + 10'd1) : v_q;
      hs_q <= !(h_q >= 10'd656 && h_q <= 10'd751);
      vs_q <= !(v_q >= 10'd490 && v_q <= 10'd491);
    end

  assign seg = seg_q;
  assign an = an_q;
  assign hsync = hs_q;
  assign vsync = vs_q;
endmodule

// File: tb/tb_bomberman_game.sv
// tb_bomberman_game: directed vector table plus hand sequences for reset state and hsync timing.
module tb_bomberman_game;
  logic clk = 1'b0;
  logic [7:0] sw = 8'h80;
  logic [7:0] JA = 8'h00;
  logic btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0, btnS = 1'b0;
  logic [7:0] seg;
  logic [3:0] an;
  logic hsync, vsync;
  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [4:0] U = 5'b00001, D = 5'b00010, L = 5'b00100, R = 5'b01000, S = 5'b10000, N = 5'b00000;

  always #5 clk = ~clk;

  bomberman_game #(.BOMB_PERIOD(200), .DEB_PERIOD(10), .REFRESH_W(6)) dut (
    .clk(clk), .sw(sw), .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR), .btnS(btnS),
    .JA(JA), .seg(seg), .an(an), .hsync(hsync), .vsync(vsync)
  );

  typedef struct {
    string name;
    logic rst;
    logic [4:0] a;
    logic [4:0] b;
    int reps;
    int hold;
    int wait_c;
    logic [2:0] ax, ay, bx, by;
    logic [1:0] ha, hb;
  } vec_t;
  vec_t v[$];

  function automatic vec_t mk(input string name, input logic rst, input logic [4:0] a, input logic [4:0] b,
                              input int reps, input int hold, input int wait_c,
                              input logic [2:0] ax, input logic [2:0] ay, input logic [2:0] bx, input logic [2:0] by,
                              input logic [1:0] ha, input logic [1:0] hb);
    vec_t t;
    t.name = name; t.rst = rst; t.a = a; t.b = b; t.reps = reps; t.hold = hold; t.wait_c = wait_c;
    t.ax = ax; t.ay = ay; t.bx = bx; t.by = by; t.ha = ha; t.hb = hb;
    return t;
  endfunction

  function automatic logic [7:0] glyph(input logic [1:0] h);
    return h == 2'd0 ? 8'hC0 : h == 2'd1 ? 8'hF9 : h == 2'd2 ? 8'hA4 : 8'hB0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [4:0] a, input logic [4:0] b);
    sw[7] = r;
    {btnS, btnR, btnL, btnD, btnU} = a;
    JA[4:0] = b;
  endtask

  // Grabs the first value seen on each digit during 80 cycles; flags bad an codes or missing digits.
  task automatic read_display(output logic [7:0] d3, output logic [7:0] d2, output logic [7:0] d1,
                              output logic [7:0] d0, output logic bad);
    logic [3:0] seen;
    seen = '0;
    bad = 1'b0;
    d3 = 8'h00; d2 = 8'h00; d1 = 8'h00; d0 = 8'h00;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (an == 4'b0111) begin if (!seen[3]) d3 = seg; seen[3] = 1'b1; end
      else if (an == 4'b1011) begin if (!seen[2]) d2 = seg; seen[2] = 1'b1; end
      else if (an == 4'b1101) begin if (!seen[1]) d1 = seg; seen[1] = 1'b1; end
      else if (an == 4'b1110) begin if (!seen[0]) d0 = seg; seen[0] = 1'b1; end
      else bad = 1'b1;
    end
    if (seen != 4'hF) bad = 1'b1;
  endtask

  initial begin
    logic [7:0] d3, d2, d1, d0;
    logic bad, prev;
    int t_fall1, t_fall2, t_rise;
    v.push_back(mk("reset", 1, N, N, 1, 20, 30, 0, 0, 7, 7, 3, 3));
    v.push_back(mk("a_down_held", 0, D, N, 1, 100, 30, 0, 1, 7, 7, 3, 3));
    v.push_back(mk("a_left_edge", 0, L, N, 1, 30, 30, 0, 1, 7, 7, 3, 3));
    v.push_back(mk("a_up", 0, U, N, 1, 30, 30, 0, 0, 7, 7, 3, 3));
    v.push_back(mk("a_down_over_right", 0, D | R, N, 1, 30, 30, 0, 1, 7, 7, 3, 3));
    v.push_back(mk("a_left_over_right_edge", 0, L | R, N, 1, 30, 30, 0, 1, 7, 7, 3, 3));
    v.push_back(mk("a_up_over_down", 0, U | D, N, 1, 30, 30, 0, 0, 7, 7, 3, 3));
    v.push_back(mk("a_bomb_arm", 0, S, N, 1, 40, 10, 0, 0, 7, 7, 3, 3));
    v.push_back(mk("a_bomb_repress", 0, S, N, 1, 40, 260, 0, 0, 7, 7, 2, 3));
    v.push_back(mk("reset2", 1, N, N, 1, 20, 30, 0, 0, 7, 7, 3, 3));
    v.push_back(mk("b_up_x7", 0, N, U, 7, 30, 30, 0, 0, 7, 0, 3, 3));
    v.push_back(mk("b_up_edge", 0, N, U, 1, 30, 30, 0, 0, 7, 0, 3, 3));
    v.push_back(mk("b_left_x6", 0, N, L, 6, 30, 30, 0, 0, 1, 0, 3, 3));
    v.push_back(mk("a_bomb_b_adjacent", 0, S, N, 1, 40, 450, 0, 0, 1, 0, 2, 2));
    v.push_back(mk("b_right_x6", 0, N, R, 6, 30, 30, 0, 0, 7, 0, 2, 2));
    v.push_back(mk("b_right_edge", 0, N, R, 1, 30, 30, 0, 0, 7, 0, 2, 2));
    v.push_back(mk("a_down", 0, D, N, 1, 30, 30, 0, 1, 7, 0, 2, 2));
    v.push_back(mk("a_right", 0, R, N, 1, 30, 30, 1, 1, 7, 0, 2, 2));
    v.push_back(mk("a_bomb_11", 0, S, N, 1, 40, 10, 1, 1, 7, 0, 2, 2));
    v.push_back(mk("a_step_21", 0, R, N, 1, 30, 30, 2, 1, 7, 0, 2, 2));
    v.push_back(mk("a_step_22", 0, D, N, 1, 30, 30, 2, 2, 7, 0, 2, 2));
    v.push_back(mk("bomb_11_diag_miss", 0, N, N, 1, 0, 300, 2, 2, 7, 0, 2, 2));
    v.push_back(mk("reset3", 1, N, N, 1, 20, 30, 0, 0, 7, 7, 3, 3));
    v.push_back(mk("ab_right_left_x3", 0, R, L, 3, 30, 30, 3, 0, 4, 7, 3, 3));
    v.push_back(mk("b_left", 0, N, L, 1, 30, 30, 3, 0, 3, 7, 3, 3));
    v.push_back(mk("ab_down_up_x3", 0, D, U, 3, 30, 30, 3, 3, 3, 4, 3, 3));
    v.push_back(mk("b_up", 0, N, U, 1, 30, 30, 3, 3, 3, 3, 3, 3));
    v.push_back(mk("both_bombs_same_cell", 0, S, S, 1, 40, 450, 3, 3, 3, 3, 1, 1));
    v.push_back(mk("b_right_x2", 0, N, R, 2, 30, 30, 3, 3, 5, 3, 1, 1));
    v.push_back(mk("a_self_bomb", 0, S, N, 1, 40, 20, 3, 3, 5, 3, 1, 1));
    v.push_back(mk("b_bomb_cancelled", 0, N, S, 1, 40, 450, 3, 3, 5, 3, 0, 1));
    v.push_back(mk("over_a_down", 0, D, N, 1, 30, 30, 3, 3, 5, 3, 0, 1));
    v.push_back(mk("over_b_left", 0, N, L, 1, 30, 30, 3, 3, 5, 3, 0, 1));
    v.push_back(mk("over_b_bomb", 0, N, S, 1, 40, 450, 3, 3, 5, 3, 0, 1));
    v.push_back(mk("reset4", 1, N, N, 1, 20, 30, 0, 0, 7, 7, 3, 3));
    v.push_back(mk("after_reset_down", 0, D, N, 1, 30, 30, 0, 1, 7, 7, 3, 3));

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_seg", seg, 8'hFF);
    check("rst_an", an, 4'hF);
    check("rst_hsync", hsync, 1'b1);
    check("rst_vsync", vsync, 1'b1);
    check("rst_pos", {dut.pa_q, dut.pb_q}, {3'd0, 3'd0, 3'd7, 3'd7});
    sw[7] = 1'b0;
    t_fall1 = -1; t_fall2 = -1; t_rise = -1; prev = 1'b1;
    for (int i = 0; i < 8000 && t_fall2 < 0; i++) begin
      @(negedge clk);
      if (prev && !hsync) begin
        if (t_fall1 < 0) t_fall1 = i;
        else t_fall2 = i;
      end
      if (!prev && hsync && t_fall1 >= 0 && t_rise < 0) t_rise = i;
      prev = hsync;
    end
    check("hsync_period", t_fall2 - t_fall1, 3200);
    check("hsync_low_width", t_rise - t_fall1, 384);

    foreach (v[k]) begin
      for (int r = 0; r < v[k].reps; r++) begin
        @(posedge clk);
        #1 drive(v[k].rst, v[k].a, v[k].b);
        repeat (v[k].hold) @(posedge clk);
        #1 drive(1'b0, N, N);
        repeat (v[k].wait_c) @(posedge clk);
      end
      @(negedge clk);
      check({v[k].name, " pos"}, {dut.pa_q, dut.pb_q}, {v[k].ax, v[k].ay, v[k].bx, v[k].by});
      read_display(d3, d2, d1, d0, bad);
      check({v[k].name, " health"}, {d3, d0}, {glyph(v[k].ha), glyph(v[k].hb)});
      check({v[k].name, " mid"}, {d2, d1}, (v[k].ha == 2'd0 || v[k].hb == 2'd0) ? 16'hA3A3 : 16'hBFBF);
      check({v[k].name, " scan"}, bad, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
